// File: rtl/time_entry_ctrl.sv
// Keypad time-entry controller: shifts BCD digit keys into an HH:MM buffer and strobes a load into the time counter.
// Build option: define TIME_RANGE_CHECK_EN to reject out-of-range times (ERROR state, entry_error pulse).
module time_entry_ctrl #(
    parameter int unsigned TIMEOUT_SEC = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       one_second,
    input  logic       key_valid,
    input  logic [3:0] key,
    input  logic       set_time,
    output logic [3:0] new_current_time_ms_hr,
    output logic [3:0] new_current_time_ls_hr,
    output logic [3:0] new_current_time_ms_min,
    output logic [3:0] new_current_time_ls_min,
    output logic       load_new_c,
    output logic       entry_busy,
    output logic       entry_error,
    output logic [2:0] digit_count
);

`ifdef TIME_RANGE_CHECK_EN
    typedef enum logic [2:0] {S_IDLE, S_ENTRY, S_CHECK, S_LOAD, S_ERROR} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_ENTRY, S_CHECK, S_LOAD} state_t;
`endif

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_SEC - 1);

    state_t     state_q, state_d;
    // dig_q[0] is tens-of-hours, dig_q[3] is units-of-minutes (newest digit).
    logic [3:0] dig_q [4];
    logic [3:0] dig_d [4];
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] tmo_q, tmo_d;
    logic       load_q, load_d;
    logic       busy_q;
    logic       is_digit, is_clear;

    assign is_digit = key_valid && (key <= 4'd9);
    assign is_clear = key_valid && (key == 4'hA);

`ifdef TIME_RANGE_CHECK_EN
    logic err_q, err_d;
    logic time_valid;

    assign time_valid = (dig_q[0] <= 4'd2) && (dig_q[2] <= 4'd5) &&
                        (dig_q[1] <= 4'd9) && (dig_q[3] <= 4'd9) &&
                        !((dig_q[0] == 4'd2) && (dig_q[1] > 4'd3));
`endif

    always_comb begin
        state_d = state_q;
        dig_d   = dig_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        load_d  = 1'b0;
`ifdef TIME_RANGE_CHECK_EN
        err_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (is_digit && !set_time) begin
                    dig_d[0] = 4'd0;
                    dig_d[1] = 4'd0;
                    dig_d[2] = 4'd0;
                    dig_d[3] = key;
                    cnt_d    = 3'd1;
                    tmo_d    = 8'd0;
                    state_d  = S_ENTRY;
                end
            end
            S_ENTRY: begin
                // set_time outranks any key arriving in the same cycle.
                if (set_time) begin
                    tmo_d   = 8'd0;
                    state_d = (cnt_q == 3'd0) ? S_IDLE : S_CHECK;
                end else if (is_digit) begin
                    for (int i = 0; i < 3; i++) dig_d[i] = dig_q[i+1];
                    dig_d[3] = key;
                    cnt_d    = (cnt_q == 3'd4) ? 3'd4 : cnt_q + 3'd1;
                    tmo_d    = 8'd0;
                end else if (is_clear) begin
                    for (int i = 0; i < 4; i++) dig_d[i] = 4'd0;
                    cnt_d = 3'd0;
                    tmo_d = 8'd0;
                end else if (one_second) begin
                    if (tmo_q == TMO_LAST) begin
                        for (int i = 0; i < 4; i++) dig_d[i] = 4'd0;
                        cnt_d   = 3'd0;
                        tmo_d   = 8'd0;
                        state_d = S_IDLE;
                    end else begin
                        tmo_d = tmo_q + 8'd1;
                    end
                end
            end
            S_CHECK: begin
`ifdef TIME_RANGE_CHECK_EN
                state_d = time_valid ? S_LOAD : S_ERROR;
`else
                state_d = S_LOAD;
`endif
            end
            S_LOAD: begin
                load_d  = 1'b1;
                state_d = S_IDLE;
            end
`ifdef TIME_RANGE_CHECK_EN
            S_ERROR: begin
                err_d = 1'b1;
                for (int i = 0; i < 4; i++) dig_d[i] = 4'd0;
                cnt_d   = 3'd0;
                state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            dig_q   <= '{default: 4'd0};
            cnt_q   <= 3'd0;
            tmo_q   <= 8'd0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dig_q   <= dig_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            load_q  <= load_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

`ifdef TIME_RANGE_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end
    assign entry_error = err_q;
`else
    assign entry_error = 1'b0;
`endif

    assign new_current_time_ms_hr  = dig_q[0];
    assign new_current_time_ls_hr  = dig_q[1];
    assign new_current_time_ms_min = dig_q[2];
    assign new_current_time_ls_min = dig_q[3];
    assign load_new_c              = load_q;
    assign entry_busy              = busy_q;
    assign digit_count             = cnt_q;

endmodule

// File: tb/tb_time_entry_ctrl.sv
// Bench for time_entry_ctrl: vector table, directed corner sequences, then random keys against a numeric model.
module tb_time_entry_ctrl;

    localparam int TMO = 5;
`ifdef TIME_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       one_second = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key = 4'd0;
    logic       set_time = 1'b0;
    logic [3:0] ms_hr, ls_hr, ms_min, ls_min;
    logic       load_new_c, entry_busy, entry_error;
    logic [2:0] digit_count;
    logic [15:0] dut_dig;

    int errors = 0;
    int checks = 0;

    time_entry_ctrl #(.TIMEOUT_SEC(TMO)) dut (
        .clk(clk), .reset(reset), .one_second(one_second),
        .key_valid(key_valid), .key(key), .set_time(set_time),
        .new_current_time_ms_hr(ms_hr), .new_current_time_ls_hr(ls_hr),
        .new_current_time_ms_min(ms_min), .new_current_time_ls_min(ls_min),
        .load_new_c(load_new_c), .entry_busy(entry_busy),
        .entry_error(entry_error), .digit_count(digit_count)
    );

    always #5 clk = ~clk;
    assign dut_dig = {ms_hr, ls_hr, ms_min, ls_min};

    typedef struct {
        logic        kv;
        logic [3:0]  k;
        logic        st;
        logic        os;
        logic [15:0] dig;
        logic [2:0]  cnt;
        logic        busy;
        logic        load;
    } vec_t;
    vec_t tbl[$];

    // Reference model: the buffer is a 4-digit decimal number.
    int m_mode, m_phase, m_value, m_ndig, m_secs;
    bit m_load, m_err;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] d, input logic [2:0] c,
                             input logic b, input logic l, input logic e);
        chk({tag, ".digits"}, dut_dig, d);
        chk({tag, ".count"}, 16'(digit_count), 16'(c));
        chk({tag, ".busy"}, 16'(entry_busy), 16'(b));
        chk({tag, ".load"}, 16'(load_new_c), 16'(l));
        chk({tag, ".error"}, 16'(entry_error), 16'(e));
    endtask

    task automatic cyc(input logic kv, input logic [3:0] k, input logic st, input logic os);
        @(negedge clk);
        key_valid = kv; key = k; set_time = st; one_second = os;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int kv, input int k, input int st, input int os,
                       input int d, input int c, input int b, input int l);
        vec_t v;
        v.kv = 1'(kv); v.k = 4'(k); v.st = 1'(st); v.os = 1'(os);
        v.dig = 16'(d); v.cnt = 3'(c); v.busy = 1'(b); v.load = 1'(l);
        tbl.push_back(v);
    endtask

    function automatic logic [15:0] bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic model_step(input logic kv, input logic [3:0] k, input logic st, input logic os);
        int hh, mm;
        m_load = 1'b0;
        m_err  = 1'b0;
        if (m_phase > 0) begin
            m_phase--;
            if (m_phase == 0) begin
                hh = m_value / 100;
                mm = m_value % 100;
                if (!RC || (hh <= 23 && mm <= 59)) begin
                    m_load = 1'b1;
                end else begin
                    m_err = 1'b1; m_value = 0; m_ndig = 0;
                end
                m_mode = 0;
            end
        end else if (m_mode == 0) begin
            if (kv && k <= 4'd9 && !st) begin
                m_value = int'(k); m_ndig = 1; m_secs = 0; m_mode = 1;
            end
        end else begin
            if (st) begin
                if (m_ndig == 0) m_mode = 0;
                else m_phase = 2;
            end else if (kv && k <= 4'd9) begin
                m_value = (m_value * 10 + int'(k)) % 10000;
                m_ndig  = (m_ndig < 4) ? m_ndig + 1 : 4;
                m_secs  = 0;
            end else if (kv && k == 4'hA) begin
                m_value = 0; m_ndig = 0; m_secs = 0;
            end else if (os) begin
                m_secs++;
                if (m_secs >= TMO) begin
                    m_mode = 0; m_value = 0; m_ndig = 0; m_secs = 0;
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic kv, st, os;
        logic [3:0] k;

        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // 12:34, 23:59 with saturation, CLEAR + simultaneous set/key, IDLE ignores, empty set, 00:00
        add(1,1,0,0,'h0001,1,1,0); add(1,2,0,0,'h0012,2,1,0); add(1,3,0,0,'h0123,3,1,0);
        add(1,4,0,0,'h1234,4,1,0); add(0,0,1,0,'h1234,4,1,0); add(0,0,0,0,'h1234,4,1,0);
        add(0,0,0,0,'h1234,4,0,1); add(0,0,0,0,'h1234,4,0,0);
        add(1,7,0,0,'h0007,1,1,0); add(1,1,0,0,'h0071,2,1,0); add(1,2,0,0,'h0712,3,1,0);
        add(1,3,0,0,'h7123,4,1,0); add(1,5,0,0,'h1235,4,1,0); add(1,9,0,0,'h2359,4,1,0);
        add(0,0,1,0,'h2359,4,1,0); add(0,0,0,0,'h2359,4,1,0); add(0,0,0,0,'h2359,4,0,1);
        add(0,0,0,0,'h2359,4,0,0);
        add(1,1,0,0,'h0001,1,1,0); add(1,2,0,0,'h0012,2,1,0); add(1,10,0,0,'h0000,0,1,0);
        add(1,9,0,0,'h0009,1,1,0); add(1,5,1,0,'h0009,1,1,0); add(0,0,0,0,'h0009,1,1,0);
        add(0,0,0,0,'h0009,1,0,1); add(0,0,0,0,'h0009,1,0,0);
        add(0,0,1,0,'h0009,1,0,0); add(1,10,0,0,'h0009,1,0,0); add(1,11,0,0,'h0009,1,0,0);
        add(1,0,0,0,'h0000,1,1,0); add(1,12,0,0,'h0000,1,1,0); add(1,10,0,0,'h0000,0,1,0);
        add(0,0,1,0,'h0000,0,0,0); add(0,0,0,0,'h0000,0,0,0);
        add(1,0,0,0,'h0000,1,1,0); add(1,0,0,0,'h0000,2,1,0); add(1,0,0,0,'h0000,3,1,0);
        add(1,0,0,0,'h0000,4,1,0); add(0,0,1,0,'h0000,4,1,0); add(0,0,0,0,'h0000,4,1,0);
        add(0,0,0,0,'h0000,4,0,1); add(0,0,0,0,'h0000,4,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].kv, tbl[i].k, tbl[i].st, tbl[i].os);
            check_all($sformatf("vec%0d", i), tbl[i].dig, tbl[i].cnt, tbl[i].busy, tbl[i].load, 1'b0);
        end

        // 24:00 is out of range
        cyc(1, 4'd2, 0, 0); cyc(1, 4'd4, 0, 0); cyc(1, 4'd0, 0, 0); cyc(1, 4'd0, 0, 0);
        cyc(0, 4'd0, 1, 0);
        cyc(0, 4'd0, 0, 0);
        check_all("t2.wait", 16'h2400, 3'd4, 1'b1, 1'b0, 1'b0);
        cyc(0, 4'd0, 0, 0);
        check_all("t2.commit", RC ? 16'h0000 : 16'h2400, RC ? 3'd0 : 3'd4, 1'b0, !RC, RC);
        cyc(0, 4'd0, 0, 0);
        check_all("t2.after", RC ? 16'h0000 : 16'h2400, RC ? 3'd0 : 3'd4, 1'b0, 1'b0, 1'b0);

        // timeout: a key on the last-but-one tick restarts the count
        cyc(1, 4'd5, 0, 0);
        for (int i = 0; i < TMO - 1; i++) begin
            cyc(0, 4'd0, 0, 1);
            cyc(0, 4'd0, 0, 0);
        end
        check_all("t4.almost", 16'h0005, 3'd1, 1'b1, 1'b0, 1'b0);
        cyc(1, 4'd6, 0, 0);
        for (int i = 0; i < TMO - 1; i++) begin
            cyc(0, 4'd0, 0, 1);
            chk("t4.noload", 16'(load_new_c), 16'd0);
        end
        check_all("t4.restart", 16'h0056, 3'd2, 1'b1, 1'b0, 1'b0);
        cyc(0, 4'd0, 0, 1);
        check_all("t4.expired", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
        cyc(0, 4'd0, 0, 0);
        chk("t4.noload_after", 16'(load_new_c), 16'd0);

        // reset while in CHECK
        cyc(1, 4'd1, 0, 0); cyc(1, 4'd2, 0, 0); cyc(1, 4'd3, 0, 0); cyc(1, 4'd4, 0, 0);
        cyc(0, 4'd0, 1, 0);
        #2 reset = 1'b1;
        #1 check_all("t6.async", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
        cyc(0, 4'd0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 4'd0, 0, 0);
            chk($sformatf("t6.noload%0d", i), 16'(load_new_c), 16'd0);
        end
        cyc(0, 4'd0, 1, 0);
        check_all("t6.idle_set", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);

        // reset while load_new_c is high
        cyc(1, 4'd1, 0, 0); cyc(1, 4'd2, 0, 0); cyc(0, 4'd0, 1, 0);
        cyc(0, 4'd0, 0, 0); cyc(0, 4'd0, 0, 0);
        chk("t6.load_hi", 16'(load_new_c), 16'd1);
        #2 reset = 1'b1;
        #1 check_all("t6.load_drop", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        m_mode = 0; m_phase = 0; m_value = 0; m_ndig = 0; m_secs = 0;
        m_load = 1'b0; m_err = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            kv = ($urandom_range(0, 9) < 4);
            k  = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
            st = ($urandom_range(0, 19) == 0);
            os = ($urandom_range(0, 4) == 0);
            model_step(kv, k, st, os);
            cyc(kv, k, st, os);
            check_all($sformatf("rnd%0d", n), bcd(m_value), 3'(m_ndig), (m_mode != 0), m_load, m_err);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
